// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the serial frame transmitter.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/baud_tick_counter.sv
// Bit-period timer: counts CLKS_PER_BIT-1 down to 0, tick marks the last cycle of each bit.
module baud_tick_counter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_timer;

  // Reload on zero rather than decrementing, so CLKS_PER_BIT=1 stays pinned at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (restart || (r_timer == '0)) begin
      r_timer <= LOAD;
    end else begin
      r_timer <= r_timer - 1'b1;
    end
  end

  assign tick = (r_timer == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// LSB-first framed serial transmitter (start 0, DATA_W bits, optional even parity, stop 1).
// Define SERIAL_TX_PARITY_EN to insert the parity bit between data and stop.
module serial_frame_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy
);

  localparam int BCW = $clog2(DATA_W + 1);

  tx_state_t         r_state;
  logic [DATA_W-1:0] r_shift;
  logic [BCW-1:0]    r_bitcnt;
  logic              r_tx;
  logic              w_tick;
  logic              w_accept;

  assign ready    = (r_state == IDLE);
  assign busy     = !ready;
  assign w_accept = valid && ready;
  assign tx       = r_tx;

  baud_tick_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .restart(w_accept),
    .tick   (w_tick)
  );

`ifdef SERIAL_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^data_in;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_tx     <= LINE_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift <= data_in;
            r_state <= START;
            r_tx    <= START_LVL;
          end
        end
        START: begin
          if (w_tick) begin
            r_tx     <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_bitcnt <= BCW'(1);
            r_state  <= DATA;
          end
        end
        // r_bitcnt holds the number of data bits already placed on the line.
        DATA: begin
          if (w_tick) begin
            if (r_bitcnt == BCW'(DATA_W)) begin
`ifdef SERIAL_TX_PARITY_EN
              r_state <= PARITY;
              r_tx    <= r_parity;
`else
              r_state <= STOP;
              r_tx    <= STOP_LVL;
`endif
            end else begin
              r_tx     <= r_shift[0];
              r_shift  <= r_shift >> 1;
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_state <= STOP;
            r_tx    <= STOP_LVL;
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
            r_tx    <= LINE_IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= LINE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: two instances (CLKS_PER_BIT 4 and 1), one monitor on the selected one.
`timescale 1ns/1ps
module tb_serial_frame_tx;

  localparam int DW = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          vld = 1'b0;
  logic          sel = 1'b0;

  logic valid4, valid1, ready4, ready1, tx4, tx1, busy4, busy1;
  logic ready_m, tx_m, busy_m;
  int   cpb_m;

  assign valid4  = vld & ~sel;
  assign valid1  = vld & sel;
  assign ready_m = sel ? ready1 : ready4;
  assign tx_m    = sel ? tx1 : tx4;
  assign busy_m  = sel ? busy1 : busy4;
  assign cpb_m   = sel ? 1 : 4;

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset(reset), .data_in(data_in), .valid(valid4),
    .ready(ready4), .tx(tx4), .busy(busy4)
  );

  serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .data_in(data_in), .valid(valid1),
    .ready(ready1), .tx(tx1), .busy(busy1)
  );

  int errors = 0;
  int checks = 0;
  int frames_done = 0;
  int frames_sent = 0;

  logic [15:0] exp_q[$];
  logic [15:0] cur;
  bit mon_active = 1'b0;
  int slot = 0, cnt = 0, gap_cnt = 0, last_gap = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected line level per bit slot: start, data LSB first, optional parity, stop.
  function automatic logic [15:0] frame_bits(input logic [DW-1:0] w);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[1+i] = w[i];
`ifdef SERIAL_TX_PARITY_EN
    f[DW+1] = ($countones(w) % 2) == 1;
`endif
    return f;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
      gap_cnt    = 0;
    end else begin
      chk("ready_vs_busy", int'(ready_m), int'(!busy_m));
      if (!mon_active) begin
        if (tx_m == 1'b0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_start", 1, 0);
          end else begin
            cur        = exp_q.pop_front();
            mon_active = 1'b1;
            slot       = 0;
            cnt        = 0;
            last_gap   = gap_cnt;
          end
        end else begin
          chk("idle_busy", int'(busy_m), 0);
          gap_cnt++;
        end
      end
      if (mon_active) begin
        chk($sformatf("slot%0d_tx", slot), int'(tx_m), int'(cur[slot]));
        chk("frame_busy", int'(busy_m), 1);
        cnt++;
        if (cnt == cpb_m) begin
          cnt = 0;
          slot++;
          if (slot == NB) begin
            mon_active = 1'b0;
            gap_cnt    = 0;
            frames_done++;
          end
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] w, input bit hold);
    int n;
    n = 0;
    vld = 1'b1;
    while (!ready_m && n < 200) begin
      data_in = DW'($urandom);
      @(negedge clk);
      n++;
    end
    if (!ready_m) begin
      chk("send_timeout", 0, 1);
      vld = 1'b0;
    end else begin
      data_in = w;
      exp_q.push_back(frame_bits(w));
      frames_sent++;
      @(posedge clk);
      #1;
      if (!hold) vld = 1'b0;
      data_in = DW'($urandom);
    end
  endtask

  task automatic wait_idle(output int n);
    int b;
    n = 0;
    b = 0;
    @(negedge clk);
    while (busy_m && b < 2000) begin
      n++;
      b++;
      @(negedge clk);
    end
    if (busy_m) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, f0;
    logic [DW-1:0] w;

    repeat (2) @(negedge clk);
    chk("rst_tx4", int'(tx4), 1);
    chk("rst_ready4", int'(ready4), 1);
    chk("rst_busy4", int'(busy4), 0);
    chk("rst_tx1", int'(tx1), 1);
    chk("rst_ready1", int'(ready1), 1);
    chk("rst_busy1", int'(busy1), 0);
    reset = 1'b0;

    repeat (20) @(negedge clk);
    chk("idle_tx", int'(tx4), 1);
    chk("idle_ready", int'(ready4), 1);

    send(8'hA5, 1'b0);
    wait_idle(n);
    chk("a5_busy_cycles", n, NB * 4);
    chk("a5_ready_back", int'(ready4), 1);

    f0 = frames_done;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b0);
    wait_idle(n);
    chk("b2b_gap", last_gap, 1);
    chk("b2b_second_len", n, NB * 4);
    repeat (2) @(negedge clk);
    chk("b2b_frames", frames_done - f0, 2);

    send(8'h3C, 1'b0);
    repeat (18) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_tx", int'(tx4), 1);
    chk("abort_busy", int'(busy4), 0);
    chk("abort_ready", int'(ready4), 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("post_rst_ready", int'(ready4), 1);
    send(8'h81, 1'b0);
    wait_idle(n);
    chk("x81_len", n, NB * 4);

    sel = 1'b1;
    @(negedge clk);
    send(8'h01, 1'b0);
    wait_idle(n);
    chk("cpb1_len", n, NB);

    for (int blk = 0; blk < 2; blk++) begin
      sel = blk[0];
      @(negedge clk);
      for (int i = 0; i < 12; i++) begin
        w = DW'($urandom);
        send(w, (i < 11) ? 1'($urandom_range(0, 1)) : 1'b0);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
      end
      wait_idle(n);
      repeat (3) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("monitor_idle", int'(mon_active), 0);
    chk("frames_done", frames_done, frames_sent - 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-to-serial frame transmitter: accepts one DATA_W-bit word via valid/ready and shifts it onto a single wire, LSB first, framed by one start bit (0) and one stop bit (1).
- Counterpart to the team's wide-to-one reduction gates: where those collapse a bus to one bit combinationally, this block spreads a bus over time onto one line.
- Feeds the board's serial output pin and the matching lab receiver.

Parameters:
- DATA_W, 8, payload bits per frame (>=1).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  DATA_W  word to send; sampled only on acceptance.
- valid  input  1  requester has a word on data_in.
- ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line, registered, idles high.
- busy  output  1  frame in progress.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high. Everything else is synchronous to the rising edge of clk.
- Reset values: tx=1, ready=1, busy=0, state=IDLE, bit counter=0, timer=0, shift register=0. Reset mid-frame aborts the frame immediately; tx goes high asynchronously and no partial frame resumes.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- ready = (state==IDLE), combinational from state. busy = !ready.
- Acceptance: valid && ready at a rising edge. On that edge:
  - data_in is latched into the shift register.
  - state <= START and tx <= 0.
- Bit timing:
  - Each serial bit (start, each data bit, parity, stop) is held on tx for exactly CLKS_PER_BIT cycles.
  - The timer counts CLKS_PER_BIT-1 down to 0; the transition fires on the cycle the timer reaches 0.
- DATA state:
  - tx = shift register bit 0 (LSB first); the register shifts right once per bit.
  - Exactly DATA_W bits are sent, tracked by a bit counter of width clog2(DATA_W+1).
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Frame length is (DATA_W+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT more with parity.
- Back-to-back frames: ready rises in the first IDLE cycle. If valid is already high, that edge accepts, so there is exactly one idle-high cycle between consecutive stop and start bits.
- While busy, valid is ignored and data_in changes do not affect the frame in flight.
- valid held low: the block stays in IDLE with tx=1 indefinitely.
- CLKS_PER_BIT=1: every bit lasts one cycle; the timer is constant 0 and must not underflow.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx carries even parity (XOR of all DATA_W latched bits) for CLKS_PER_BIT cycles. Parity is computed at acceptance from the latched word.
- Undefined: no PARITY state; DATA goes straight to STOP. No parity logic is synthesised.

Decomposition:
- Package serial_tx_pkg holds:
  - typedef tx_state_t enum {IDLE, START, DATA, PARITY, STOP}.
  - constants for line idle level (1), start level (0) and stop level (1).
- One sub-module, baud_tick_counter:
  - parameter CLKS_PER_BIT; inputs clk, reset, restart.
  - output tick, high on the last cycle of each bit period.
  - The transmitter instantiates it once.

Test Plan:
- Reset, then idle 20 cycles with valid=0 -> tx=1, ready=1, busy=0 throughout.
- CLKS_PER_BIT=4, send 8'hA5 -> tx per 4-cycle slot: 0,1,0,1,0,0,1,0,1,1. busy high 40 cycles. ready returns the cycle after the last stop cycle.
- Hold valid=1 with 8'h00 then 8'hFF -> two frames separated by exactly one idle-high cycle. Second frame payload is all ones. data_in toggling mid-frame has no effect on tx.
- Assert reset during data bit 3 of 8'h3C -> tx=1 immediately. After release: ready=1, busy=0, and the next accepted word 8'h81 transmits correctly from its start bit.
- CLKS_PER_BIT=1, send 8'h01 -> 10-cycle frame 0,1,0,0,0,0,0,0,0,1 with no extra cycles.
- With SERIAL_TX_PARITY_EN defined:
  - 8'hA5 -> parity slot 0.
  - 8'h07 -> parity slot 1.
  - Frame is 44 cycles at CLKS_PER_BIT=4.
